// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, frame length and FIFO beat type for conv_out_requant
package conv_pkg;

  localparam int Y_W            = 21;
  localparam int Q_W            = 8;
  localparam int CONV_FRAME_LEN = 97;

  typedef struct packed {
    logic                  last;
    logic signed [Q_W-1:0] data;
  } q_beat_t;

endpackage

// File: rtl/conv_out_fifo.sv
// rtl/conv_out_fifo.sv - small synchronous FIFO of q_beat_t entries with occupancy count
module conv_out_fifo
  import conv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(q_beat_t)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard the strobes so an overflowing push or an underflowing pop is ignored.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/conv_out_requant.sv
// rtl/conv_out_requant.sv - requantize y to 8-bit with round/saturate, buffer and frame-tag (option: CONV_RELU_EN)
module conv_out_requant
  import conv_pkg::*;
#(
  parameter int IN_W       = Y_W,
  parameter int OUT_W      = Q_W,
  parameter int SHIFT      = 8,
  parameter int FRAME_LEN  = CONV_FRAME_LEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IN_W-1:0]  s_data_in_y,
  input  logic             s_valid_y,
  output logic             s_ready_y,
  output logic [OUT_W-1:0] m_data_out_q,
  output logic             m_valid_q,
  input  logic             m_ready_q,
  output logic             m_last_q
);

  localparam int T_W   = IN_W + 1;
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic signed [T_W-1:0] ROUND = T_W'(2 ** (SHIFT - 1));
  localparam logic signed [T_W-1:0] Q_MAX = T_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [T_W-1:0] Q_MIN = -T_W'(2 ** (OUT_W - 1));

  logic signed [T_W-1:0]  t_s, r_s;
  logic [OUT_W-1:0]       q_s;
  logic [CNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [OUT_W-1:0]       hold_q, hold_d;
  logic                   push, pop, frame_end;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  q_beat_t                in_beat, head_beat;

  // Ready depends only on stored occupancy, never on the downstream ready.
  assign s_ready_y = !fifo_full;
  assign m_valid_q = (fifo_count != '0);
  assign push      = s_valid_y && s_ready_y;
  assign pop       = m_valid_q && m_ready_q;
  assign frame_end = (frame_cnt_q == CNT_W'(FRAME_LEN - 1));

  // Round-half-up arithmetic shift, optional ReLU clamp, then signed saturation.
  always_comb begin
    t_s = $signed({s_data_in_y[IN_W-1], s_data_in_y}) + ROUND;
    r_s = t_s >>> SHIFT;
`ifdef CONV_RELU_EN
    if (r_s[T_W-1]) r_s = '0;
`endif
    if (r_s > Q_MAX)      q_s = Q_MAX[OUT_W-1:0];
    else if (r_s < Q_MIN) q_s = Q_MIN[OUT_W-1:0];
    else                  q_s = r_s[OUT_W-1:0];
  end

  assign in_beat = '{last: frame_end, data: q_s};

  conv_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_data_i(in_beat),
    .pop_i      (pop),
    .head_o     (head_beat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  // While empty the data port repeats the most recently popped value.
  assign m_data_out_q = fifo_empty ? hold_q : head_beat.data;
  assign m_last_q     = !fifo_empty && head_beat.last;

  // Frame position advances per accepted beat; the popped value is remembered for the empty case.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    if (push) frame_cnt_d = frame_end ? '0 : frame_cnt_q + CNT_W'(1);
    if (pop)  hold_d = head_beat.data;
  end

  // Frame counter and held-output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      hold_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_conv_out_requant.sv
// tb/tb_conv_out_requant.sv - randomized self-checking bench for conv_out_requant (option: CONV_RELU_EN)
module tb_conv_out_requant;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] s_data_in_y = '0;
  logic        s_valid_y = 1'b0;
  logic        s_ready_y;
  logic [7:0]  m_data_out_q;
  logic        m_valid_q;
  logic        m_ready_q = 1'b0;
  logic        m_last_q;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q[$];
  int         m_fcnt = 0;

  conv_out_requant dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_data_in_y (s_data_in_y),
    .s_valid_y   (s_valid_y),
    .s_ready_y   (s_ready_y),
    .m_data_out_q(m_data_out_q),
    .m_valid_q   (m_valid_q),
    .m_ready_q   (m_ready_q),
    .m_last_q    (m_last_q)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_requant(input int y);
    int t, r;
    t = y + 128;
    r = (t >= 0) ? t / 256 : -((-t + 255) / 256);
`ifdef CONV_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  function automatic void model_accept(input logic [7:0] q);
    exp_q.push_back({(m_fcnt == 96), q});
    m_fcnt = (m_fcnt == 96) ? 0 : m_fcnt + 1;
  endfunction

  function automatic int rand_y();
    logic signed [20:0] w;
    if ($urandom_range(0, 1) == 1) begin
      w = 21'($urandom);
      return int'(w);
    end
    return int'($urandom_range(0, 70000)) - 35000;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    s_valid_y = 1'b0;
    m_ready_q = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    m_fcnt = 0;
  endtask

  // Drives one clock cycle of inputs and reports what the DUT showed mid-cycle.
  task automatic cycle(input logic v, input int y, input logic r,
                       output logic acc, output logic mv, output logic sr,
                       output logic [7:0] qd, output logic ql);
    @(negedge clk);
    s_valid_y   = v;
    s_data_in_y = v ? 21'(y) : 21'h15A5A;
    m_ready_q   = r;
    #1;
    acc = v && s_ready_y;
    mv  = m_valid_q;
    sr  = s_ready_y;
    qd  = m_data_out_q;
    ql  = m_last_q;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++; if (m_valid_q !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", m_valid_q); end
    n_checks++; if (m_last_q !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b expected 0", m_last_q); end
    n_checks++; if (m_data_out_q !== 8'd0) begin n_errors++; $display("FAIL reset_data: got %0d expected 0", m_data_out_q); end
    n_checks++; if (s_ready_y !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", s_ready_y); end
    apply_reset();
  endtask

  task automatic test_requant_values();
    int dy[7] = '{28336, 177328, -5456, -56144, 128, -128, 127};
`ifdef CONV_RELU_EN
    int de[7] = '{111, 127, 0, 0, 1, 0, 0};
`else
    int de[7] = '{111, 127, -21, -128, 1, 0, 0};
`endif
    logic acc, mv, sr, ql, v, r;
    logic [7:0] qd;
    logic [8:0] e;
    int sent, cur_y;
    for (int i = 0; i < 10; i++) begin
      cycle(i < 7, (i < 7) ? dy[i] : 0, 1'b1, acc, mv, sr, qd, ql);
      if (mv) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL requant_directed: unexpected beat data=%0d", $signed(qd)); end
        else begin
          e = exp_q.pop_front();
          if ({ql, qd} !== e) begin n_errors++; $display("FAIL requant_directed: got %0d last=%b expected %0d last=%b", $signed(qd), ql, $signed(e[7:0]), e[8]); end
        end
      end
      if (i < 7) begin
        n_checks++; if (acc !== 1'b1) begin n_errors++; $display("FAIL requant_accept: beat %0d got %b expected 1", i, acc); end
        if (acc) model_accept(8'(de[i]));
      end
    end
    sent = 0;
    cur_y = rand_y();
    for (int i = 0; i < 400 && (sent < 60 || exp_q.size() != 0); i++) begin
      v = (sent < 60) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, cur_y, r, acc, mv, sr, qd, ql);
      n_checks++; if (mv !== (exp_q.size() != 0)) begin n_errors++; $display("FAIL requant_valid: got %b expected %b", mv, exp_q.size() != 0); end
      if (mv && r) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL requant_random: unexpected beat data=%0d", $signed(qd)); end
        else begin
          e = exp_q.pop_front();
          if ({ql, qd} !== e) begin n_errors++; $display("FAIL requant_random: got %0d last=%b expected %0d last=%b", $signed(qd), ql, $signed(e[7:0]), e[8]); end
        end
      end
      if (acc) begin model_accept(ref_requant(cur_y)); sent++; cur_y = rand_y(); end
    end
    n_checks++; if (exp_q.size() != 0 || sent != 60) begin n_errors++; $display("FAIL requant_drain: sent=%0d left=%0d expected 60 and 0", sent, exp_q.size()); end
  endtask

  task automatic test_frame_tagging();
    logic acc, mv, sr, ql, v, r;
    logic [7:0] qd;
    logic [8:0] e;
    int sent, out_idx, cur_y;
    apply_reset();
    sent = 0; out_idx = 0; cur_y = rand_y();
    for (int i = 0; i < 2000 && (sent < 194 || exp_q.size() != 0); i++) begin
      v = (sent < 194) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      cycle(v, cur_y, r, acc, mv, sr, qd, ql);
      if (mv && r) begin
        n_checks++;
        if (ql !== (out_idx == 96 || out_idx == 193)) begin n_errors++; $display("FAIL frame_last: beat %0d got %b expected %b", out_idx, ql, (out_idx == 96 || out_idx == 193)); end
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL frame_data: unexpected beat %0d", out_idx); end
        else begin
          e = exp_q.pop_front();
          if (qd !== e[7:0]) begin n_errors++; $display("FAIL frame_data: beat %0d got %0d expected %0d", out_idx, $signed(qd), $signed(e[7:0])); end
        end
        out_idx++;
      end
      if (acc) begin model_accept(ref_requant(cur_y)); sent++; cur_y = rand_y(); end
    end
    n_checks++; if (out_idx != 194) begin n_errors++; $display("FAIL frame_count: got %0d beats expected 194", out_idx); end
  endtask

  task automatic test_backpressure();
    logic acc, mv, sr, ql, held_set;
    logic [7:0] qd;
    logic [8:0] e, held;
    int by[6];
    int accepted;
    apply_reset();
    for (int k = 0; k < 6; k++) by[k] = rand_y();
    accepted = 0; held_set = 1'b0; held = '0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, by[k], 1'b0, acc, mv, sr, qd, ql);
      if (mv) begin
        if (!held_set) begin held = {ql, qd}; held_set = 1'b1; end
        else begin
          n_checks++; if ({ql, qd} !== held) begin n_errors++; $display("FAIL bp_head_stable: got %0d expected %0d", $signed(qd), $signed(held[7:0])); end
        end
      end
      if (acc) begin model_accept(ref_requant(by[k])); accepted++; end
    end
    n_checks++; if (accepted != 4) begin n_errors++; $display("FAIL bp_accepted: got %0d expected 4", accepted); end
    // Full with a simultaneous pop: still not ready.
    cycle(1'b1, rand_y(), 1'b1, acc, mv, sr, qd, ql);
    n_checks++; if (sr !== 1'b0 || acc !== 1'b0) begin n_errors++; $display("FAIL bp_full_ready: got ready=%b accept=%b expected 0 0", sr, acc); end
    for (int i = 0; i < 10 && (mv || i == 0); i++) begin
      if (i != 0) cycle(1'b0, 0, 1'b1, acc, mv, sr, qd, ql);
      if (mv) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL bp_order: unexpected beat data=%0d", $signed(qd)); end
        else begin
          e = exp_q.pop_front();
          if ({ql, qd} !== e) begin n_errors++; $display("FAIL bp_order: got %0d expected %0d", $signed(qd), $signed(e[7:0])); end
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL bp_drain: %0d beats missing expected 0", exp_q.size()); end
    n_checks++; if (sr !== 1'b1) begin n_errors++; $display("FAIL bp_ready_return: got %b expected 1", sr); end
    n_checks++; if (m_data_out_q !== e[7:0]) begin n_errors++; $display("FAIL bp_empty_hold: got %0d expected %0d", $signed(m_data_out_q), $signed(e[7:0])); end
  endtask

  task automatic test_throughput();
    logic acc, mv, sr, ql;
    logic [7:0] qd;
    logic [8:0] e;
    int y;
    apply_reset();
    for (int i = 0; i < 98; i++) begin
      y = rand_y();
      cycle(i < 97, y, 1'b1, acc, mv, sr, qd, ql);
      n_checks++; if (mv !== (i >= 1)) begin n_errors++; $display("FAIL tput_valid: cycle %0d got %b expected %b", i, mv, i >= 1); end
      if (mv) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL tput_data: unexpected beat cycle %0d", i); end
        else begin
          e = exp_q.pop_front();
          if ({ql, qd} !== e) begin n_errors++; $display("FAIL tput_data: cycle %0d got %0d last=%b expected %0d last=%b", i, $signed(qd), ql, $signed(e[7:0]), e[8]); end
        end
      end
      if (i < 97) begin
        n_checks++; if (acc !== 1'b1) begin n_errors++; $display("FAIL tput_accept: cycle %0d got %b expected 1", i, acc); end
        if (acc) model_accept(ref_requant(y));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic acc, mv, sr, ql;
    logic [7:0] qd;
    logic [8:0] e;
    int y, out_idx;
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      y = rand_y();
      cycle(1'b1, y, i < 48, acc, mv, sr, qd, ql);
      if (mv && i < 48 && exp_q.size() != 0) void'(exp_q.pop_front());
      if (acc) model_accept(ref_requant(y));
    end
    n_checks++; if (m_valid_q !== 1'b1 || exp_q.size() != 3) begin n_errors++; $display("FAIL mid_buffered: got valid=%b model=%0d expected 1 and 3", m_valid_q, exp_q.size()); end
    @(negedge clk);
    s_valid_y = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_valid_q !== 1'b0) begin n_errors++; $display("FAIL mid_async_valid: got %b expected 0", m_valid_q); end
    n_checks++; if (s_ready_y !== 1'b1) begin n_errors++; $display("FAIL mid_async_ready: got %b expected 1", s_ready_y); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    m_fcnt = 0;
    out_idx = 0;
    for (int i = 0; i < 100; i++) begin
      y = rand_y();
      cycle(i < 97, y, 1'b1, acc, mv, sr, qd, ql);
      if (mv) begin
        n_checks++;
        if (ql !== (out_idx == 96)) begin n_errors++; $display("FAIL mid_last: beat %0d got %b expected %b", out_idx, ql, out_idx == 96); end
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL mid_data: unexpected beat %0d", out_idx); end
        else begin
          e = exp_q.pop_front();
          if (qd !== e[7:0]) begin n_errors++; $display("FAIL mid_data: beat %0d got %0d expected %0d", out_idx, $signed(qd), $signed(e[7:0])); end
        end
        out_idx++;
      end
      if (acc) model_accept(ref_requant(y));
    end
    n_checks++; if (out_idx != 97) begin n_errors++; $display("FAIL mid_count: got %0d beats expected 97", out_idx); end
  endtask

  initial begin
    test_reset();
    test_requant_values();
    test_frame_tagging();
    test_backpressure();
    test_throughput();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
